// File: rtl/cache_line_serializer.sv
// Cache line serializer: accepts a 4-word cache line and sends it as four
// beats on an AXI/ACE R channel, with one beat per cycle when RREADY is high.
// Optional feature macro: CACHE_LINE_SERIALIZER_WRAP_EN. When it is defined,
// the critical word is sent first and the word order wraps. When it is
// undefined, crit_word is ignored and words go out in order 0..3.
module cache_line_serializer #(
  parameter int unsigned DATA_SIZE = 128,
  parameter int unsigned ID_WIDTH  = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   line_valid,
  output logic                   line_ready,
  input  logic [DATA_SIZE*4-1:0] cache_line_in,
  input  logic [ID_WIDTH-1:0]    line_id,
  input  logic [3:0]             line_resp,
  input  logic [1:0]             crit_word,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [DATA_SIZE-1:0]   RDATA,
  output logic [ID_WIDTH-1:0]    RID,
  output logic [3:0]             RRESP,
  output logic                   RLAST,
  output logic                   busy
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  // Holds line_ready low until the first edge after reset release.
  logic                   ready_en_q;
  logic [DATA_SIZE*4-1:0] line_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [3:0]             resp_q;
  logic [1:0]             word_idx;
  logic                   accept;
  logic                   hs;
  logic                   last_hs;

  assign RVALID     = (state_q == StSend);
  assign RLAST      = RVALID && (beat_q == 2'd3);
  assign busy       = RVALID;
  assign hs         = RVALID && RREADY;
  assign last_hs    = hs && RLAST;
  // In SEND, a new line can only be taken while the last beat is leaving.
  assign line_ready = ready_en_q && ((state_q == StIdle) || last_hs);
  assign accept     = line_valid && line_ready;
  assign RID        = id_q;
  assign RRESP      = resp_q;

`ifdef CACHE_LINE_SERIALIZER_WRAP_EN
  logic [1:0] crit_q;

  // Capture the critical word index with the line.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      crit_q <= 2'd0;
    end else if (accept) begin
      crit_q <= crit_word;
    end
  end

  // 2-bit add wraps modulo 4.
  assign word_idx = crit_q + beat_q;
`else
  logic unused_crit;
  assign unused_crit = ^crit_word;
  assign word_idx    = beat_q;
`endif

  // Select the word for the current beat.
  always_comb begin
    RDATA = line_q[DATA_SIZE-1:0];
    unique case (word_idx)
      2'd0: RDATA = line_q[0*DATA_SIZE +: DATA_SIZE];
      2'd1: RDATA = line_q[1*DATA_SIZE +: DATA_SIZE];
      2'd2: RDATA = line_q[2*DATA_SIZE +: DATA_SIZE];
      2'd3: RDATA = line_q[3*DATA_SIZE +: DATA_SIZE];
      default: RDATA = line_q[DATA_SIZE-1:0];
    endcase
  end

  // Next state and beat counter.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (accept) begin
      state_d = StSend;
      beat_d  = 2'd0;
    end else if (hs) begin
      if (beat_q == 2'd3) begin
        state_d = StIdle;
        beat_d  = 2'd0;
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end
  end

  // State, beat counter and ready-enable registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= StIdle;
      beat_q     <= 2'd0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      ready_en_q <= 1'b1;
    end
  end

  // Capture the line payload on acceptance.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      line_q <= '0;
      id_q   <= '0;
      resp_q <= 4'd0;
    end else if (accept) begin
      line_q <= cache_line_in;
      id_q   <= line_id;
      resp_q <= line_resp;
    end
  end

endmodule

// File: tb/tb_cache_line_serializer.sv
// Directed bench for cache_line_serializer. Inputs change on the falling edge,
// and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_cache_line_serializer;

  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 4;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic            line_valid;
  logic            line_ready;
  logic [DW*4-1:0] cache_line_in;
  logic [IDW-1:0]  line_id;
  logic [3:0]      line_resp;
  logic [1:0]      crit_word;
  logic            RVALID;
  logic            RREADY;
  logic [DW-1:0]   RDATA;
  logic [IDW-1:0]  RID;
  logic [3:0]      RRESP;
  logic            RLAST;
  logic            busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  cache_line_serializer #(.DATA_SIZE(DW), .ID_WIDTH(IDW)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .line_valid    (line_valid),
    .line_ready    (line_ready),
    .cache_line_in (cache_line_in),
    .line_id       (line_id),
    .line_resp     (line_resp),
    .crit_word     (crit_word),
    .RVALID        (RVALID),
    .RREADY        (RREADY),
    .RDATA         (RDATA),
    .RID           (RID),
    .RRESP         (RRESP),
    .RLAST         (RLAST),
    .busy          (busy)
  );

  always #5 ACLK = ~ACLK;

  // Word w of a line with the given base is base + w.
  function automatic logic [DW*4-1:0] mk_line(input logic [DW-1:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Offer a line at the current falling edge; it is taken on the next rising edge.
  task automatic offer(input logic [DW-1:0] base, input logic [3:0] id, input logic [3:0] resp,
                       input logic [1:0] crit);
    line_valid    = 1'b1;
    cache_line_in = mk_line(base);
    line_id       = id;
    line_resp     = resp;
    crit_word     = crit;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0; line_valid = 1'b0; RREADY = 1'b0;
    cache_line_in = '0; line_id = '0; line_resp = '0; crit_word = '0;
    repeat (2) @(negedge ACLK);
    #1;
    chk_cnt++; if ({RVALID, RLAST, busy, line_ready} !== 4'b0000)
      $display("FAIL rst_ctrl got %b want 0000", {RVALID, RLAST, busy, line_ready});
    else pass_cnt++;
    chk_cnt++; if ({RDATA, RID, RRESP} !== '0)
      $display("FAIL rst_data got %h/%h/%h want 0", RDATA, RID, RRESP);
    else pass_cnt++;
    @(negedge ACLK); ARESETn = 1'b1; #1;
    chk_cnt++; if (line_ready !== 1'b0)
      $display("FAIL rst_ready_before_edge got %b want 0", line_ready);
    else pass_cnt++;
    @(negedge ACLK); #1;
    chk_cnt++; if (line_ready !== 1'b1)
      $display("FAIL rst_ready_after_edge got %b want 1", line_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    @(negedge ACLK); offer(32'hA0, 4'h3, 4'h0, 2'd0); RREADY = 1'b1;
    @(negedge ACLK); line_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++; if (RVALID !== 1'b1 || busy !== 1'b1 || RDATA !== 32'hA0 + k
                     || RLAST !== (k == 3))
        $display("FAIL basic_beat%0d got v=%b b=%b d=%h l=%b want v=1 b=1 d=%h l=%b",
                 k, RVALID, busy, RDATA, RLAST, 32'hA0 + k, k == 3);
      else pass_cnt++;
      @(negedge ACLK);
    end
    #1;
    chk_cnt++; if ({RVALID, busy, line_ready} !== 3'b001)
      $display("FAIL basic_idle got %b want 001", {RVALID, busy, line_ready});
    else pass_cnt++;
  endtask

  task automatic test_crit_word;
    int idx;
    @(negedge ACLK); offer(32'hB0, 4'h1, 4'h1, 2'd2); RREADY = 1'b1;
    @(negedge ACLK); line_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_LINE_SERIALIZER_WRAP_EN
      idx = (2 + k) % 4;
`else
      idx = k;
`endif
      #1;
      chk_cnt++; if (RDATA !== 32'hB0 + idx || RLAST !== (k == 3))
        $display("FAIL crit_beat%0d got d=%h l=%b want d=%h l=%b",
                 k, RDATA, RLAST, 32'hB0 + idx, k == 3);
      else pass_cnt++;
      @(negedge ACLK);
    end
  endtask

  task automatic test_stall;
    logic [6:0] pat;
    int beat;
    pat  = 7'b1101001;  // bit i is RREADY in cycle i: 1,0,0,1,0,1,1
    beat = 0;
    @(negedge ACLK); offer(32'hC0, 4'h5, 4'h4, 2'd0);
    @(negedge ACLK); line_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      RREADY = pat[i];
      #1;
      chk_cnt++; if (RVALID !== 1'b1 || RDATA !== 32'hC0 + beat || RID !== 4'h5
                     || RRESP !== 4'h4 || RLAST !== (beat == 3)
                     || line_ready !== (beat == 3 && pat[i]))
        $display("FAIL stall_cyc%0d got v=%b d=%h id=%h r=%h l=%b rdy=%b want beat %0d",
                 i, RVALID, RDATA, RID, RRESP, RLAST, line_ready, beat);
      else pass_cnt++;
      if (pat[i]) beat++;
      @(negedge ACLK);
    end
    RREADY = 1'b1; #1;
    chk_cnt++; if (RVALID !== 1'b0)
      $display("FAIL stall_done got v=%b want 0", RVALID);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    @(negedge ACLK); offer(32'hD0, 4'h1, 4'h0, 2'd0); RREADY = 1'b1;
    @(negedge ACLK); offer(32'hE0, 4'h2, 4'h0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) line_valid = 1'b0;
      #1;
      chk_cnt++; if (RVALID !== 1'b1 || RDATA !== ((k < 4) ? 32'hD0 + k : 32'hE0 + k - 4)
                     || RID !== ((k < 4) ? 4'h1 : 4'h2) || RLAST !== (k % 4 == 3)
                     || line_ready !== (k % 4 == 3))
        $display("FAIL b2b_beat%0d got v=%b d=%h id=%h l=%b rdy=%b", k, RVALID, RDATA, RID,
                 RLAST, line_ready);
      else pass_cnt++;
      @(negedge ACLK);
    end
    #1;
    chk_cnt++; if (RVALID !== 1'b0)
      $display("FAIL b2b_done got v=%b want 0", RVALID);
    else pass_cnt++;
  endtask

  task automatic test_hold_off;
    @(negedge ACLK); offer(32'h10, 4'h6, 4'h2, 2'd0); RREADY = 1'b0;
    @(negedge ACLK); offer(32'h20, 4'h7, 4'h3, 2'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_cnt++; if (line_ready !== 1'b0 || RID !== 4'h6 || RDATA !== 32'h10)
        $display("FAIL hold_stall%0d got rdy=%b id=%h d=%h want 0/6/10", i, line_ready, RID,
                 RDATA);
      else pass_cnt++;
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++; if (RID !== 4'h6 || RDATA !== 32'h10 + k || line_ready !== (k == 3))
        $display("FAIL hold_beat%0d got id=%h d=%h rdy=%b", k, RID, RDATA, line_ready);
      else pass_cnt++;
      @(negedge ACLK);
    end
    line_valid = 1'b0; #1;
    chk_cnt++; if (RVALID !== 1'b1 || RID !== 4'h7 || RRESP !== 4'h3 || RDATA !== 32'h20)
      $display("FAIL hold_second got v=%b id=%h r=%h d=%h want 1/7/3/20", RVALID, RID, RRESP,
               RDATA);
    else pass_cnt++;
    repeat (4) @(negedge ACLK);
    #1;
    chk_cnt++; if (RVALID !== 1'b0)
      $display("FAIL hold_done got v=%b want 0", RVALID);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    @(negedge ACLK); offer(32'hF0, 4'h9, 4'h1, 2'd0); RREADY = 1'b1;
    @(negedge ACLK); line_valid = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b0; #1;
    chk_cnt++; if ({RVALID, RLAST, busy, line_ready} !== 4'b0000)
      $display("FAIL rstmid_ctrl got %b want 0000", {RVALID, RLAST, busy, line_ready});
    else pass_cnt++;
    @(negedge ACLK); ARESETn = 1'b1;
    @(negedge ACLK); #1;
    chk_cnt++; if (RVALID !== 1'b0 || line_ready !== 1'b1)
      $display("FAIL rstmid_idle got v=%b rdy=%b want 0/1", RVALID, line_ready);
    else pass_cnt++;
    @(negedge ACLK); offer(32'h50, 4'h4, 4'h0, 2'd0);
    @(negedge ACLK); line_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++; if (RVALID !== 1'b1 || RDATA !== 32'h50 + k || RID !== 4'h4
                     || RLAST !== (k == 3))
        $display("FAIL rstmid_beat%0d got v=%b d=%h id=%h l=%b", k, RVALID, RDATA, RID, RLAST);
      else pass_cnt++;
      @(negedge ACLK);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_crit_word;
    test_stall;
    test_back_to_back;
    test_hold_off;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cache_line_serializer.md
CACHE_LINE_SERIALIZER -- requirements
Module: cache_line_serializer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 128, giving the R beat width in bits; one cache line is 4 beats.
REQ-002 The block SHALL have parameter ID_WIDTH, default 4, giving the RID width.
REQ-003 The block SHALL have port ACLK  input  1  the only clock; all state is on its rising edge.
REQ-004 The block SHALL have port ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port line_valid  input  1  a selected cache line is offered.
REQ-006 The block SHALL have port line_ready  output  1  the block can accept the offered line.
REQ-007 The block SHALL have port cache_line_in  input  DATA_SIZE*4  the line; word w is bits [w*DATA_SIZE +: DATA_SIZE].
REQ-008 The block SHALL have port line_id  input  ID_WIDTH  transaction ID returned on RID.
REQ-009 The block SHALL have port line_resp  input  4  ACE response returned on RRESP ([1:0] OKAY/EXOKAY/SLVERR/DECERR, [2] PassDirty, [3] IsShared).
REQ-010 The block SHALL have port crit_word  input  2  index of the word to send first.
REQ-011 The block SHALL have ports RVALID out 1, RREADY in 1, RDATA out DATA_SIZE, RID out ID_WIDTH, RRESP out 4, RLAST out 1, forming the AXI/ACE R channel.
REQ-012 The block SHALL have port busy  output  1  a line is captured and not fully sent.

Function
REQ-013 A line SHALL be accepted on any ACLK edge where line_valid and line_ready are both 1; cache_line_in, line_id, line_resp and crit_word SHALL be captured on that edge.
REQ-014 The state machine SHALL have two states: IDLE and SEND.
REQ-015 In IDLE, line_ready SHALL be 1; acceptance SHALL move the state to SEND with the beat counter at 0.
REQ-016 In SEND, line_ready SHALL be 1 only in the cycle where the last beat is handed off (RVALID, RREADY and RLAST all 1); otherwise it SHALL be 0.
REQ-017 Acceptance on a last-beat handshake SHALL keep the state in SEND and start the new line with no idle cycle between lines.
REQ-018 A last-beat handshake with no acceptance SHALL return the state to IDLE.
REQ-019 RVALID SHALL be 1 exactly when the state is SEND; the first beat SHALL appear on the cycle after acceptance, so latency is 1 cycle.
REQ-020 Beat k (k = 0..3) SHALL carry word (crit_word + k) mod 4; the 2-bit index SHALL wrap modulo 4.
REQ-021 RLAST SHALL be 1 only on beat 3.
REQ-022 RID and RRESP SHALL hold the captured values on all 4 beats.
REQ-023 The beat counter SHALL advance only on an RVALID and RREADY handshake.
REQ-024 While RVALID is 1 and RREADY is 0, RDATA, RID, RRESP and RLAST SHALL hold stable.
REQ-025 RVALID SHALL never deassert before the handshake that completes its beat.
REQ-026 A line SHALL take at least 4 cycles to send, with one cycle per beat when RREADY is held at 1.
REQ-027 busy SHALL be 1 exactly when the state is SEND.

Reset
REQ-028 While ARESETn is 0, the state SHALL be IDLE and the beat counter SHALL be 0.
REQ-029 While ARESETn is 0, RVALID, RLAST, busy, RDATA, RID and RRESP SHALL all be 0, and line_ready SHALL be 0.
REQ-030 Once ARESETn has been released and one ACLK edge has passed, line_ready SHALL be 1.
REQ-031 Reset asserted during a line SHALL discard that line with no further beats; the next line SHALL be new.

Configuration
REQ-032 The block SHALL provide macro CACHE_LINE_SERIALIZER_WRAP_EN.
REQ-033 With CACHE_LINE_SERIALIZER_WRAP_EN defined, beat order SHALL follow REQ-020, sending the critical word first and wrapping.
REQ-034 With CACHE_LINE_SERIALIZER_WRAP_EN undefined, crit_word SHALL be ignored and beat k SHALL carry word k.

Verification
REQ-035 The bench SHALL cover: line words {A0,A1,A2,A3}, crit_word=0, RREADY=1 -> RDATA A0,A1,A2,A3 on 4 consecutive cycles starting 1 cycle after acceptance, RLAST only on A3.
REQ-036 The bench SHALL cover: crit_word=2 with WRAP_EN defined -> beats A2,A3,A0,A1; same stimulus with WRAP_EN undefined -> beats A0,A1,A2,A3.
REQ-037 The bench SHALL cover: RREADY pattern 1,0,0,1,0,1,1 -> each beat held stable through the stall cycles, 4 handshakes in total, RID=0x5 and RRESP=0x4 on every beat.
REQ-038 The bench SHALL cover: two lines offered back-to-back with RREADY=1 -> line_ready=1 on the RLAST cycle, 8 beats on 8 consecutive cycles, second line's RID on beats 5-8.
REQ-039 The bench SHALL cover: ARESETn driven to 0 after beat 1 -> RVALID, RLAST and busy go to 0 immediately; after release, the next line starts at its first beat.
REQ-040 The bench SHALL cover: line_valid=1 throughout a transfer that has RREADY=0 -> no second acceptance until the RLAST handshake.
